// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter in front of a single-ported data memory.
// Each accepted request takes three cycles: accept (IDLE), memory access
// (ACCESS) and a one-cycle response strobe (RESP).
module dmem_arbiter #(
  parameter int unsigned MEM_BYTES = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  // port 0: load/store unit
  input  logic        req0_valid,
  input  logic        req0_wr,
  input  logic [31:0] req0_addr,
  input  logic [31:0] req0_wdata,
  output logic        req0_ready,
  output logic        rsp0_valid,
  output logic [31:0] rsp0_rdata,
  output logic        rsp0_err,
  // port 1: DMA/debug
  input  logic        req1_valid,
  input  logic        req1_wr,
  input  logic [31:0] req1_addr,
  input  logic [31:0] req1_wdata,
  output logic        req1_ready,
  output logic        rsp1_valid,
  output logic [31:0] rsp1_rdata,
  output logic        rsp1_err,
  // data memory
  output logic [31:0] mem_addr,
  output logic        mem_wr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StAccess = 2'd1;
  localparam logic [1:0] StResp   = 2'd2;

  // Highest legal word-aligned byte address.
  localparam logic [31:0] MaxAddr = 32'(MEM_BYTES - 4);

  logic [1:0]  state_q, state_d;
  logic        prio_q, prio_d;     // port favoured on a tie
  logic        port_q, port_d;     // port owning the in-flight transaction
  logic        wr_q, wr_d;
  logic        err_q, err_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata0_q, rdata0_d;
  logic        rerr0_q, rerr0_d;
  logic [31:0] rdata1_q, rdata1_d;
  logic        rerr1_q, rerr1_d;

  logic        in_idle;
  logic        gnt0, gnt1, accept;
  logic        sel_wr;
  logic [31:0] sel_addr, sel_wdata;
  logic [31:0] rsp_data;

  // Arbitration: a lone requester wins; on a tie the favoured port wins.
  always_comb begin
    in_idle   = (state_q == StIdle) && rst_n;
    gnt0      = in_idle && req0_valid && (!req1_valid || !prio_q);
    gnt1      = in_idle && req1_valid && (!req0_valid || prio_q);
    accept    = gnt0 || gnt1;
    sel_wr    = gnt1 ? req1_wr    : req0_wr;
    sel_addr  = gnt1 ? req1_addr  : req0_addr;
    sel_wdata = gnt1 ? req1_wdata : req0_wdata;
  end

  // Next-state logic for the FSM, request latches and response registers.
  always_comb begin
    state_d  = state_q;
    prio_d   = prio_q;
    port_d   = port_q;
    wr_d     = wr_q;
    err_d    = err_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata0_d = rdata0_q;
    rerr0_d  = rerr0_q;
    rdata1_d = rdata1_q;
    rerr1_d  = rerr1_q;

    // Rejected accesses return zero; writes echo their data.
    if (err_q) begin
      rsp_data = 32'h0000_0000;
    end else if (wr_q) begin
      rsp_data = wdata_q;
    end else begin
      rsp_data = mem_rdata;
    end

    case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StAccess;
          prio_d  = gnt0;  // favour the other port next time
          port_d  = gnt1;
          wr_d    = sel_wr;
          addr_d  = sel_addr;
          wdata_d = sel_wdata;
          err_d   = (sel_addr[1:0] != 2'b00) || (sel_addr > MaxAddr);
        end
      end
      StAccess: begin
        state_d = StResp;
        if (port_q) begin
          rdata1_d = rsp_data;
          rerr1_d  = err_q;
        end else begin
          rdata0_d = rsp_data;
          rerr0_d  = err_q;
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      prio_q   <= 1'b0;
      port_q   <= 1'b0;
      wr_q     <= 1'b0;
      err_q    <= 1'b0;
      addr_q   <= 32'h0000_0000;
      wdata_q  <= 32'h0000_0000;
      rdata0_q <= 32'h0000_0000;
      rerr0_q  <= 1'b0;
      rdata1_q <= 32'h0000_0000;
      rerr1_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      prio_q   <= prio_d;
      port_q   <= port_d;
      wr_q     <= wr_d;
      err_q    <= err_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata0_q <= rdata0_d;
      rerr0_q  <= rerr0_d;
      rdata1_q <= rdata1_d;
      rerr1_q  <= rerr1_d;
    end
  end

  // Outputs; everything is forced low while reset is asserted so a
  // pending write or response cannot leak out.
  always_comb begin
    req0_ready = gnt0;
    req1_ready = gnt1;
    mem_addr   = addr_q;
    mem_wdata  = wdata_q;
    mem_wr     = rst_n && (state_q == StAccess) && wr_q && !err_q;
    rsp0_valid = rst_n && (state_q == StResp) && !port_q;
    rsp1_valid = rst_n && (state_q == StResp) && port_q;
    rsp0_rdata = rst_n ? rdata0_q : 32'h0000_0000;
    rsp0_err   = rst_n && rerr0_q;
    rsp1_rdata = rst_n ? rdata1_q : 32'h0000_0000;
    rsp1_err   = rst_n && rerr1_q;
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a byte-wide big-endian memory model.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req0_wr, req0_ready, rsp0_valid, rsp0_err;
  logic [31:0] req0_addr, req0_wdata, rsp0_rdata;
  logic        req1_valid, req1_wr, req1_ready, rsp1_valid, rsp1_err;
  logic [31:0] req1_addr, req1_wdata, rsp1_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_wr;

  int total = 0;
  int bad   = 0;
  int wr_cnt = 0;
  int r0_cnt = 0;
  int snap;

  logic [7:0] mem [256];
  logic       mem_init_q = 1'b0;
  logic [7:0] ma;

  always #5 clk = ~clk;

  dmem_arbiter #(.MEM_BYTES(256)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_wr    (req0_wr),
    .req0_addr  (req0_addr),
    .req0_wdata (req0_wdata),
    .req0_ready (req0_ready),
    .rsp0_valid (rsp0_valid),
    .rsp0_rdata (rsp0_rdata),
    .rsp0_err   (rsp0_err),
    .req1_valid (req1_valid),
    .req1_wr    (req1_wr),
    .req1_addr  (req1_addr),
    .req1_wdata (req1_wdata),
    .req1_ready (req1_ready),
    .rsp1_valid (rsp1_valid),
    .rsp1_rdata (rsp1_rdata),
    .rsp1_err   (rsp1_err),
    .mem_addr   (mem_addr),
    .mem_wr     (mem_wr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  // Memory model: byte i preloads to (i + 0x10) mod 256.
  assign ma = mem_addr[7:0];
  always_comb mem_rdata = {mem[ma], mem[ma + 8'd1], mem[ma + 8'd2], mem[ma + 8'd3]};

  always @(posedge clk) begin
    if (!mem_init_q) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'(i + 16);
      mem_init_q <= 1'b1;
    end else if (mem_wr) begin
      mem[ma]        <= mem_wdata[31:24];
      mem[ma + 8'd1] <= mem_wdata[23:16];
      mem[ma + 8'd2] <= mem_wdata[15:8];
      mem[ma + 8'd3] <= mem_wdata[7:0];
    end
  end

  always @(posedge clk) begin
    if (mem_wr) wr_cnt <= wr_cnt + 1;
    if (rsp0_valid) r0_cnt <= r0_cnt + 1;
  end

  function automatic logic [31:0] word_at(input logic [7:0] a);
    return {mem[a], mem[a + 8'd1], mem[a + 8'd2], mem[a + 8'd3]};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic drive(input bit p, input logic v, input logic wr,
                       input logic [31:0] a, input logic [31:0] d);
    if (p) begin
      req1_valid = v; req1_wr = wr; req1_addr = a; req1_wdata = d;
    end else begin
      req0_valid = v; req0_wr = wr; req0_addr = a; req0_wdata = d;
    end
  endtask

  // One single-port transaction, checked phase by phase.
  task automatic txn(input bit p, input logic wr, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [31:0] exp_data,
                     input logic exp_err);
    int n;
    @(posedge clk); #1;
    drive(p, 1'b1, wr, addr, wdata);
    #1;
    n = 0;
    while (!(p ? req1_ready : req0_ready) && n < 20) begin
      @(posedge clk); #2;
      n++;
    end
    check("grant", 32'(p ? req1_ready : req0_ready), 32'd1);
    check("grant_excl", 32'(p ? req0_ready : req1_ready), 32'd0);
    @(posedge clk); #1;
    drive(p, 1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    check("acc_memwr", 32'(mem_wr), 32'(wr & ~exp_err));
    check("acc_addr", mem_addr, addr);
    check("acc_rdy", 32'(req0_ready | req1_ready), 32'd0);
    @(posedge clk); #2;
    check("rsp_valid", 32'(p ? rsp1_valid : rsp0_valid), 32'd1);
    check("rsp_other", 32'(p ? rsp0_valid : rsp1_valid), 32'd0);
    check("rsp_data", p ? rsp1_rdata : rsp0_rdata, exp_data);
    check("rsp_err", 32'(p ? rsp1_err : rsp0_err), 32'(exp_err));
    check("rsp_memwr", 32'(mem_wr), 32'd0);
    @(posedge clk); #2;
    check("rsp_end", 32'(rsp0_valid | rsp1_valid), 32'd0);
  endtask

  initial begin
    int n;
    bit exp_p;
    rst_n = 1'b0;
    drive(0, 1'b1, 1'b0, 32'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0);

    // Reset: every output low even with a request pending.
    repeat (2) @(posedge clk);
    #2;
    check("rst_rdy0", 32'(req0_ready), 32'd0);
    check("rst_rdy1", 32'(req1_ready), 32'd0);
    check("rst_rspv", 32'(rsp0_valid | rsp1_valid), 32'd0);
    check("rst_rdata", rsp0_rdata | rsp1_rdata, 32'd0);
    check("rst_err", 32'(rsp0_err | rsp1_err), 32'd0);
    check("rst_memwr", 32'(mem_wr), 32'd0);
    check("rst_maddr", mem_addr, 32'd0);
    check("rst_mwdata", mem_wdata, 32'd0);

    // Both ports requesting continuously: grants alternate 0,1,0,1.
    @(posedge clk); #1;
    rst_n = 1'b1;
    drive(0, 1'b1, 1'b0, 32'h00, 32'h0);
    drive(1, 1'b1, 1'b0, 32'h04, 32'h0);
    #1;
    for (int k = 0; k < 4; k++) begin
      exp_p = k[0];
      n = 0;
      while (!(req0_ready | req1_ready) && n < 20) begin
        @(posedge clk); #2;
        n++;
      end
      check("rr_gnt0", 32'(req0_ready), 32'(!exp_p));
      check("rr_gnt1", 32'(req1_ready), 32'(exp_p));
      @(posedge clk); #2;
      check("rr_acc_rdy", 32'(req0_ready | req1_ready), 32'd0);
      @(posedge clk); #2;
      check("rr_rspv0", 32'(rsp0_valid), 32'(!exp_p));
      check("rr_rspv1", 32'(rsp1_valid), 32'(exp_p));
      check("rr_data", exp_p ? rsp1_rdata : rsp0_rdata,
            exp_p ? 32'h1415_1617 : 32'h1011_1213);
      if (k < 3) begin
        @(posedge clk); #2;
      end
    end
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0);

    // Write then read back, big-endian byte order.
    snap = wr_cnt;
    txn(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0);
    check("wr_pulses", 32'(wr_cnt - snap), 32'd1);
    check("byte10", 32'(mem[8'h10]), 32'hDE);
    check("byte11", 32'(mem[8'h11]), 32'hAD);
    check("byte12", 32'(mem[8'h12]), 32'hBE);
    check("byte13", 32'(mem[8'h13]), 32'hEF);
    txn(0, 1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0);

    // Rejected writes on port 1 and address boundaries.
    snap = wr_cnt;
    txn(1, 1'b1, 32'h02, 32'h1234_5678, 32'h0, 1'b1);
    txn(1, 1'b1, 32'hFD, 32'h1234_5678, 32'h0, 1'b1);
    check("err_nowr", 32'(wr_cnt - snap), 32'd0);
    check("err_mem00", word_at(8'h00), 32'h1011_1213);
    txn(0, 1'b0, 32'hFC, 32'h0, 32'h0C0D_0E0F, 1'b0);
    txn(0, 1'b0, 32'h100, 32'h0, 32'h0, 1'b1);

    // Port 1 waits through port 0's ACCESS/RESP; a one-cycle port 0 pulse is ignored.
    @(posedge clk); #1;
    drive(0, 1'b1, 1'b0, 32'h10, 32'h0);
    #1;
    check("wait_gnt0", 32'(req0_ready), 32'd1);
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1, 1'b1, 1'b0, 32'h04, 32'h0);
    #1;
    check("wait_acc_rdy1", 32'(req1_ready), 32'd0);
    @(posedge clk); #1;
    req0_valid = 1'b1;
    #1;
    check("wait_rsp_rdy1", 32'(req1_ready), 32'd0);
    check("wait_rsp_rdy0", 32'(req0_ready), 32'd0);
    check("wait_rsp0", rsp0_rdata, 32'hDEAD_BEEF);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    #1;
    snap = r0_cnt;
    check("wait_idle_rdy1", 32'(req1_ready), 32'd1);
    check("wait_idle_rdy0", 32'(req0_ready), 32'd0);
    @(posedge clk); #1;
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
    @(posedge clk); #2;
    check("wait_rsp1v", 32'(rsp1_valid), 32'd1);
    check("wait_rsp1d", rsp1_rdata, 32'h1415_1617);
    repeat (4) @(posedge clk);
    #2;
    check("pulse_no_txn", 32'(r0_cnt - snap), 32'd0);

    // Reset during ACCESS kills the write and the response.
    snap = wr_cnt;
    n = r0_cnt;
    @(posedge clk); #1;
    drive(0, 1'b1, 1'b1, 32'h20, 32'hCAFE_F00D);
    #1;
    check("rstacc_gnt", 32'(req0_ready), 32'd1);
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    rst_n = 1'b0;
    #1;
    check("rstacc_memwr", 32'(mem_wr), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    check("rstacc_rspv", 32'(rsp0_valid), 32'd0);
    repeat (2) @(posedge clk);
    #2;
    check("rstacc_nrsp", 32'(r0_cnt - n), 32'd0);
    check("rstacc_nowr", 32'(wr_cnt - snap), 32'd0);
    check("rstacc_mem20", word_at(8'h20), 32'h3031_3233);
    drive(0, 1'b1, 1'b0, 32'h00, 32'h0);
    drive(1, 1'b1, 1'b0, 32'h04, 32'h0);
    #1;
    check("rst_tie0", 32'(req0_ready), 32'd1);
    check("rst_tie1", 32'(req1_ready), 32'd0);
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (3) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter: MEM_BYTES, 256, byte size of the shared data memory; legal word addresses are 0..MEM_BYTES-4.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset; one clock; reset is synchronous and active-low.
REQ-004 req0_valid  input  1  port 0 (load/store unit) request.
REQ-005 req0_wr  input  1  port 0 write (1) / read (0).
REQ-006 req0_addr  input  32  port 0 byte address.
REQ-007 req0_wdata  input  32  port 0 write data, big-endian (bits 31:24 at addr).
REQ-008 req0_ready  output  1  port 0 request accepted this cycle.
REQ-009 rsp0_valid  output  1  port 0 response strobe, one cycle.
REQ-010 rsp0_rdata  output  32  port 0 read data / write echo.
REQ-011 rsp0_err  output  1  port 0 access rejected.
REQ-012 req1_valid, req1_wr, req1_addr, req1_wdata, req1_ready, rsp1_valid, rsp1_rdata, rsp1_err: port 1 (DMA/debug), same directions, widths and meanings as port 0.
REQ-013 mem_addr  output  32  byte address to the data memory.
REQ-014 mem_wr  output  1  write enable to the data memory.
REQ-015 mem_wdata  output  32  write data to the data memory.
REQ-016 mem_rdata  input  32  combinational read data from the data memory at mem_addr.

Function
REQ-017 FSM states IDLE, ACCESS, RESP; IDLE->ACCESS on acceptance, ACCESS->RESP always, RESP->IDLE always.
REQ-018 Acceptance occurs only in IDLE; reqN_ready is combinational, high only for the winning port in IDLE; both ready never high together.
REQ-019 Arbitration: single valid wins; both valid -> port not granted last (round-robin pointer, updated on each acceptance).
REQ-020 On acceptance latch port, wr, addr, wdata; error flag = (addr[1:0]!=0) or (addr>MEM_BYTES-4).
REQ-021 ACCESS: mem_addr/mem_wdata driven from latched values; mem_wr=1 for exactly this cycle iff latched wr=1, error=0, rst_n=1.
REQ-022 End of ACCESS: capture mem_rdata (read) or latched wdata (write) into response data; error -> response data 0x00000000.
REQ-023 RESP: rspN_valid=1 for one cycle on latched port only, with rdata and err; other port rsp_valid=0; no response backpressure.
REQ-024 Latency: acceptance edge E; rsp_valid high in the cycle after edge E+1; next acceptance possible at edge E+3 (max one transaction per 3 cycles).
REQ-025 mem_addr/mem_wdata hold last latched values outside ACCESS; mem_wr=0 outside ACCESS.
REQ-026 Requester holds valid/wr/addr/wdata stable until ready; valid dropped before ready -> no transaction, no pointer update.
REQ-027 Requests arriving during ACCESS/RESP wait; not lost, not acknowledged.
REQ-028 rsp_rdata/rsp_err hold last value between responses; only rsp_valid qualifies them.

Reset
REQ-029 rst_n=0 at an edge: state=IDLE, pointer favours port 0 on first tie, all latches 0, mem_addr=0, mem_wdata=0.
REQ-030 During reset all outputs 0: ready, rsp_valid, rsp_rdata, rsp_err, mem_wr.
REQ-031 Reset mid-ACCESS suppresses the pending write (mem_wr gated by rst_n); reset mid-ACCESS or mid-RESP drops the response.

Verification
REQ-032 Port 0 write addr 0x10 data 0xDEADBEEF, then read 0x10 -> mem_wr one cycle; bytes 0x10..0x13 = DE,AD,BE,EF; read rsp0_rdata=0xDEADBEEF, rsp0_err=0, rsp_valid 2 cycles after acceptance.
REQ-033 Both ports valid continuously after reset, reads of 0x00 and 0x04 -> grants alternate 0,1,0,1; each response on correct port only.
REQ-034 Port 1 write addr 0x02 (misaligned) or 0xFD (out of range) -> rsp1_err=1, rsp1_rdata=0, mem_wr never high, memory unchanged.
REQ-035 Port 0 write 0x20 accepted, rst_n=0 during ACCESS -> mem_wr=0 that cycle, no rsp0_valid, memory at 0x20 unchanged; after release port 0 wins first tie.
REQ-036 req1_valid raised while port 0 transaction in ACCESS -> req1_ready=0 until IDLE, then port 1 accepted; req0_valid pulsed one cycle while not ready -> no transaction.
